// File: rtl/rsa_mon_pkg.sv
// Shared types and defaults for the RSA self-composition leak monitor.
package rsa_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;
  localparam logic [CNT_W_DEF-1:0] LAT_NONE = '1;

endpackage

// File: rtl/finish_capture.sv
// Per-copy capture of first-finish latency and decrypt check.
// Later finish pulses are ignored until the next clear.
module finish_capture
  import rsa_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_W-1:0]     cyc,
  input  logic                 finish,
  input  logic [2*WIDTH-1:0]   m_dec,
  input  logic [2*WIDTH-1:0]   m_q,
  output logic                 seen,
  output logic [CNT_W-1:0]     lat,
  output logic                 err
);

  logic             seen_q;
  logic [CNT_W-1:0] lat_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      lat_q  <= '0;
      err_q  <= 1'b0;
    end else if (clr) begin
      seen_q <= 1'b0;
      lat_q  <= '0;
      err_q  <= 1'b0;
    end else if (en && finish && !seen_q) begin
      seen_q <= 1'b1;
      lat_q  <= cyc;
      err_q  <= (m_dec != m_q);
    end
  end

  assign seen = seen_q;
  assign lat  = lat_q;
  assign err  = err_q;

endmodule

// File: rtl/rsa_leak_monitor.sv
// Leak monitor for two self-composed RSA copies: latency per copy, first
// finish divergence, decrypt check and run timeout. All outputs registered.
module rsa_leak_monitor
  import rsa_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 KeyGenStart,
  input  logic [2*WIDTH-1:0]   m,
  input  logic                 finish_1,
  input  logic                 finish_2,
  input  logic [2*WIDTH-1:0]   m_decrypted_1,
  input  logic [2*WIDTH-1:0]   m_decrypted_2,
  output logic                 busy,
  output logic                 done,
  output logic                 leak,
  output logic [CNT_W-1:0]     diverge_cyc,
  output logic [CNT_W-1:0]     lat_1,
  output logic [CNT_W-1:0]     lat_2,
  output logic                 err_1,
  output logic                 err_2,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] TMO     = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAT_ALL = {CNT_W{1'b1}};

  mon_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] m_q;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   diverge_q, diverge_d;
  logic               leak_q, leak_d;
  logic               timeout_q, timeout_d;

  logic               cap_en;
  logic               seen_1, seen_2;
  logic [CNT_W-1:0]   cap_lat_1, cap_lat_2;
  logic               both_fin;
  logic               at_limit;

  // A restart in the same cycle as a finish wins: capture is disabled.
  assign cap_en   = (state_q == RUN) && !KeyGenStart;
  assign both_fin = (seen_1 | finish_1) & (seen_2 | finish_2);
  assign at_limit = (cyc_q == TMO);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    diverge_d = diverge_q;
    leak_d    = leak_q;
    timeout_d = timeout_q;
    if (KeyGenStart) begin
      state_d   = RUN;
      cyc_d     = '0;
      diverge_d = '0;
      leak_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == RUN) begin
      if (!at_limit) begin
        cyc_d = cyc_q + CNT_W'(1);
      end
      if ((finish_1 != finish_2) && !leak_q) begin
        leak_d    = 1'b1;
        diverge_d = cyc_q;
      end
      if (both_fin) begin
        state_d = DONE;
      end else if (at_limit) begin
        timeout_d = 1'b1;
        leak_d    = 1'b1;
        state_d   = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      cyc_q     <= '0;
      diverge_q <= '0;
      leak_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      diverge_q <= diverge_d;
      leak_q    <= leak_d;
      timeout_q <= timeout_d;
      if (KeyGenStart) begin
        m_q <= m;
      end
    end
  end

  finish_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cap_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (KeyGenStart),
    .en     (cap_en),
    .cyc    (cyc_q),
    .finish (finish_1),
    .m_dec  (m_decrypted_1),
    .m_q    (m_q),
    .seen   (seen_1),
    .lat    (cap_lat_1),
    .err    (err_1)
  );

  finish_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cap_2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (KeyGenStart),
    .en     (cap_en),
    .cyc    (cyc_q),
    .finish (finish_2),
    .m_dec  (m_decrypted_2),
    .m_q    (m_q),
    .seen   (seen_2),
    .lat    (cap_lat_2),
    .err    (err_2)
  );

  // A copy that never finished before the timeout reports all-ones latency.
  assign lat_1       = (timeout_q && !seen_1) ? LAT_ALL : cap_lat_1;
  assign lat_2       = (timeout_q && !seen_2) ? LAT_ALL : cap_lat_2;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign leak        = leak_q;
  assign timeout     = timeout_q;
  assign diverge_cyc = diverge_q;

endmodule

// File: doc/rsa_leak_monitor.md
# rsa_leak_monitor

Cycle-accurate monitor that consumes the outputs of the two self-composed RSA copies (same `m`, different secret `p`/`q`). It measures each copy's completion latency from `KeyGenStart`, flags the first cycle in which `finish_1` and `finish_2` diverge, and checks both decrypted messages against the plaintext. It sits directly downstream of the self-composition top and gives simulation and FPGA runs the same leak verdict that the formal `finish_1 == finish_2` property checks.

## Interface
- `WIDTH`, default 8: prime width; messages are `2*WIDTH` bits.
- `CNT_W`, default 16: latency counter width.
- `TIMEOUT`, default 16'hFFFF: cycle count at which a run is abandoned; must be ≤ 2^CNT_W−1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `KeyGenStart`, in, 1: run start, the same signal driven to both RSA copies.
- `m`, in, 2*WIDTH: plaintext presented to both copies.
- `finish_1` / `finish_2`, in, 1 each: completion flags of copy 1 and copy 2.
- `m_decrypted_1` / `m_decrypted_2`, in, 2*WIDTH each: decrypted results.
- `busy`, out, 1: run in progress.
- `done`, out, 1: verdict valid; held until the next run starts.
- `leak`, out, 1: the finish flags differed in at least one cycle of the run.
- `diverge_cyc`, out, CNT_W: cycle index of the first divergence.
- `lat_1` / `lat_2`, out, CNT_W each: cycle index at which each copy's finish first rose.
- `err_1` / `err_2`, out, 1 each: decrypted result did not equal `m`.
- `timeout`, out, 1: the run hit `TIMEOUT` before both copies finished.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: all outputs hold their reset values. `KeyGenStart`=1 latches `m` into `m_q`, clears all result registers, clears `cyc` to 0, and moves to RUN.
- RUN:
  - `cyc` increments every cycle.
  - Per copy: the first cycle in which `finish_k`=1 latches `lat_k`=`cyc`, sets `fin_k_seen`, and compares `m_decrypted_k` against `m_q`; `err_k` is set on mismatch. Later finish pulses are ignored.
  - The first cycle in which `finish_1`≠`finish_2` sets `leak` and latches `diverge_cyc`=`cyc`. Later divergences do not change `diverge_cyc`.
  - Exit to DONE when both `fin_k_seen` are set, counting finishes seen this cycle.
  - If `cyc`==`TIMEOUT` first, set `timeout` and `leak` (one copy hung or both hung) and go to DONE. Any unset `lat_k` is forced to all-ones.
- DONE: `done`=1 and all results hold. `KeyGenStart`=1 behaves exactly as it does in IDLE.
- `KeyGenStart`=1 in RUN aborts the run and restarts it the same way, with no `done` pulse. The restart takes priority over any finish seen in that cycle.
- Arithmetic: `cyc` is unsigned CNT_W and never wraps, because the `TIMEOUT` bound stops it. All comparisons are full 2*WIDTH equality.

## Timing
- Reset values: `busy`=0, `done`=0, `leak`=0, `timeout`=0, `err_1`=`err_2`=0, `lat_1`=`lat_2`=0, `diverge_cyc`=0. State is IDLE.
- `KeyGenStart` is sampled at edge T. `busy`=1 from T+1, and the cycle at T+1 has index `cyc`=0.
- A finish sampled at cycle index c gives `lat_k`=c, visible from the following cycle.
- Both finishes at index c: `done`=1 and `busy`=0 one cycle later. All outputs are registered, with no combinational path from inputs to outputs.
- Simultaneous finishes at the same index give `leak`=0 and `lat_1`=`lat_2`.
- A `rst_n` assertion mid-run returns to reset values immediately. Any RSA output arriving after reset is ignored until the next `KeyGenStart`.

## Structure
- Package `rsa_mon_pkg`:
  - State enum `mon_state_t` {IDLE, RUN, DONE}.
  - `CNT_W` and `TIMEOUT` defaults.
  - `LAT_NONE` = all-ones latency constant.
- Sub-module `finish_capture`, instantiated once per copy. Inputs: `clk`, `rst_n`, `clr`, `en`, `cyc`, `finish`, `m_dec`, `m_q`. Outputs: `seen`, `lat`, `err`. The top holds the FSM, `cyc`, the divergence logic and the timeout logic.

## Test plan
- Equal latency, correct results: `m`=16'h0042, both finishes rise at index 37 with correct data → `done`, `leak`=0, `lat_1`=`lat_2`=37, `diverge_cyc`=0, `err`=0.
- Leaking pair: `finish_1` at index 20, `finish_2` at index 25 → `leak`=1, `diverge_cyc`=20, `lat_1`=20, `lat_2`=25, and `done` one cycle after index 25.
- Wrong decrypt: `m_decrypted_2`=`m`^1 at finish → `err_2`=1, `err_1`=0, `leak`=0.
- Hung copy with `TIMEOUT`=100: `finish_2` never rises → `timeout`=1, `leak`=1, `lat_2`=all-ones, `done` one cycle after `cyc`=100.
- Restart mid-run: `KeyGenStart` again at index 10 → no `done`, counters restart at 0, new `m` is latched, and the second run's latencies are reported.
- Reset mid-run: `rst_n` low at index 15 → all outputs return to 0 asynchronously. A later finish without `KeyGenStart` leaves `done`=0.
